// File: rtl/ccff_bitstream_loader.sv
// rtl/ccff_bitstream_loader.sv - serialises a config bitstream onto the ccff chain and verifies it via a sync pattern
//
// Shifts SYNC_PAT followed by exactly CHAIN_LEN bitstream bits (MSB first) into
// the configuration chain head. It then checks that SYNC_PAT arrives intact at
// the chain tail before it reports done.
//
// Ports:
//   prog_clk     programming clock (shared with the chain clock gate)
//   prog_rst_n   asynchronous active-low reset
//   start        load request pulse; honoured in IDLE, DONE and ERROR only
//   word_in      bitstream word, MSB shifted first
//   word_valid   word_in valid
//   word_ready   loader accepts word_in this cycle (registered)
//   ccff_head    serial data to chain head (registered)
//   ccff_clk_en  chain clock-gate enable; one chain shift per enabled edge (registered)
//   ccff_tail    serial data from chain tail
//   busy         load in progress (SYNC or DATA)
//   done         load finished, sync pattern verified
//   error        load finished, sync pattern corrupted at the tail
module ccff_bitstream_loader #(
    parameter int                WORD_W    = 8,
    parameter int                CHAIN_LEN = 1024,
    parameter int                SYNC_W    = 8,
    parameter logic [SYNC_W-1:0] SYNC_PAT  = 8'hA5,
    parameter int                CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              prog_rst_n,
    input  logic              start,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              ccff_clk_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_DONE,
        S_ERROR
    } state_t;

    localparam int               BL_W      = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LEN_C     = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] CHK_END   = CNT_W'(CHAIN_LEN + SYNC_W);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);

    state_t            state;
    logic [CNT_W-1:0]  edge_cnt;   // enabled edges completed since start
    logic [CNT_W-1:0]  data_cnt;   // data bits driven (or being driven) so far
    logic [CNT_W-1:0]  sync_cnt;   // index of the sync bit currently on ccff_head
    logic [SYNC_W-1:0] out_pat;    // sync bits still to be driven, next at MSB
    logic [SYNC_W-1:0] chk_pat;    // sync bits still expected at the tail, next at MSB
    logic [WORD_W-1:0] word_sreg;  // pending bits of the current word, next at MSB
    logic [BL_W-1:0]   bits_left;  // number of valid bits in word_sreg
    logic              mismatch;

    logic             tail_check;
    logic             tail_bad;
    logic             mismatch_next;
    logic             handshake;
    logic [CNT_W-1:0] data_cnt_inc;

    // The edge about to happen is number edge_cnt+1; the tail bit present
    // now is the one the chain presents just before that edge.
    assign tail_check    = ccff_clk_en && (edge_cnt >= LEN_C) && (edge_cnt < CHK_END);
    assign tail_bad      = tail_check && (ccff_tail != chk_pat[SYNC_W-1]);
    assign mismatch_next = mismatch || tail_bad;
    assign handshake     = word_ready && word_valid;
    assign data_cnt_inc  = data_cnt + CNT_W'(1);

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            state       <= S_IDLE;
            edge_cnt    <= '0;
            data_cnt    <= '0;
            sync_cnt    <= '0;
            out_pat     <= '0;
            chk_pat     <= '0;
            word_sreg   <= '0;
            bits_left   <= '0;
            mismatch    <= 1'b0;
            word_ready  <= 1'b0;
            ccff_head   <= 1'b0;
            ccff_clk_en <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            mismatch <= mismatch_next;
            if (tail_check) begin
                chk_pat <= chk_pat << 1;
            end
            if (ccff_clk_en) begin
                edge_cnt <= edge_cnt + CNT_W'(1);
            end

            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state       <= S_SYNC;
                        edge_cnt    <= '0;
                        data_cnt    <= '0;
                        sync_cnt    <= '0;
                        mismatch    <= 1'b0;
                        chk_pat     <= SYNC_PAT;
                        out_pat     <= SYNC_PAT << 1;
                        ccff_head   <= SYNC_PAT[SYNC_W-1];
                        ccff_clk_en <= 1'b1;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        error       <= 1'b0;
                    end
                end

                S_SYNC: begin
                    if (sync_cnt == SYNC_LAST) begin
                        // Last sync bit shifts on this edge; wait for the first word.
                        state       <= S_DATA;
                        ccff_clk_en <= 1'b0;
                        word_ready  <= 1'b1;
                        bits_left   <= '0;
                    end else begin
                        ccff_head <= out_pat[SYNC_W-1];
                        out_pat   <= out_pat << 1;
                        sync_cnt  <= sync_cnt + CNT_W'(1);
                    end
                end

                S_DATA: begin
                    if (handshake) begin
                        ccff_head   <= word_in[WORD_W-1];
                        word_sreg   <= word_in << 1;
                        bits_left   <= BL_W'(WORD_W - 1);
                        data_cnt    <= data_cnt_inc;
                        ccff_clk_en <= 1'b1;
                        word_ready  <= (WORD_W == 1) && (data_cnt_inc != LEN_C);
                    end else if ((bits_left != '0) && (data_cnt != LEN_C)) begin
                        ccff_head   <= word_sreg[WORD_W-1];
                        word_sreg   <= word_sreg << 1;
                        bits_left   <= bits_left - BL_W'(1);
                        data_cnt    <= data_cnt_inc;
                        ccff_clk_en <= 1'b1;
                        // Raise ready while the last buffered bit is on the head so
                        // back-to-back words stream without a bubble.
                        word_ready  <= (bits_left == BL_W'(1)) && (data_cnt_inc != LEN_C);
                    end else if (data_cnt == LEN_C) begin
                        // Final enabled edge happens now; leftover word LSBs are dropped.
                        ccff_clk_en <= 1'b0;
                        word_ready  <= 1'b0;
                        busy        <= 1'b0;
                        done        <= !mismatch_next;
                        error       <= mismatch_next;
                        state       <= mismatch_next ? S_ERROR : S_DONE;
                    end else begin
                        // Starved: hold the chain until a word arrives.
                        ccff_clk_en <= 1'b0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// tb/tb_ccff_bitstream_loader.sv - self-checking bench for ccff_bitstream_loader with a behavioural chain model
module tb_ccff_bitstream_loader;

    localparam int         WORD_W    = 8;
    localparam int         CHAIN_LEN = 20;
    localparam int         SYNC_W    = 4;
    localparam int         TOTAL     = CHAIN_LEN + SYNC_W;
    localparam logic [3:0] PAT       = 4'b1010;

    logic              prog_clk = 1'b0;
    logic              prog_rst_n;
    logic              start;
    logic [WORD_W-1:0] word_in;
    logic              word_valid;
    logic              word_ready;
    logic              ccff_head;
    logic              ccff_clk_en;
    logic              ccff_tail;
    logic              busy;
    logic              done;
    logic              error;

    int checks = 0;
    int errors = 0;

    // Behavioural chain: chain[0] is the stage nearest the head.
    logic [CHAIN_LEN-1:0] chain = '0;
    int                   chain_stages = CHAIN_LEN;

    // Monitors
    int          cyc = 0;
    int          edges = 0;
    int          last_edge_cyc = 0;
    int          hs_cnt = 0;
    logic [23:0] stream_cap = '0;
    logic [23:0] acc_w = '0;

    typedef struct {
        logic [7:0] w0;
        logic [7:0] w1;
        logic [7:0] w2;
        int         gap;
        int         stages;
        bit         spam;
        bit         exp_done;
        bit         exp_err;
    } vec_t;

    vec_t tbl[6];

    ccff_bitstream_loader #(
        .WORD_W   (WORD_W),
        .CHAIN_LEN(CHAIN_LEN),
        .SYNC_W   (SYNC_W),
        .SYNC_PAT (PAT),
        .CNT_W    (16)
    ) dut (
        .prog_clk   (prog_clk),
        .prog_rst_n (prog_rst_n),
        .start      (start),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .ccff_head  (ccff_head),
        .ccff_clk_en(ccff_clk_en),
        .ccff_tail  (ccff_tail),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 prog_clk = ~prog_clk;

    assign ccff_tail = chain[chain_stages-1];

    always @(posedge prog_clk) begin
        if (ccff_clk_en) begin
            chain <= {chain[CHAIN_LEN-2:0], ccff_head};
        end
    end

    always @(posedge prog_clk) begin
        cyc <= cyc + 1;
        if (prog_rst_n && ccff_clk_en) begin
            edges         <= edges + 1;
            last_edge_cyc <= cyc + 1;
            stream_cap    <= {stream_cap[22:0], ccff_head};
        end
        if (prog_rst_n && word_valid && word_ready) begin
            hs_cnt <= hs_cnt + 1;
            acc_w  <= {acc_w[15:0], word_in};
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bits in shift order: the sync pattern, then the words MSB first, cut to CHAIN_LEN data bits.
    function automatic logic [23:0] model_stream(input logic [7:0] a, input logic [7:0] b,
                                                 input logic [7:0] c);
        logic [27:0] all;
        all = {PAT, a, b, c};
        return all[27:4];
    endfunction

    // A chain of 'stages' flops presents, before edge e, the bit driven at edge e-stages.
    function automatic logic model_err(input logic [23:0] s, input int stages);
        logic bad;
        int   e;
        int   n;
        bad = 1'b0;
        for (int j = 0; j < SYNC_W; j++) begin
            e = CHAIN_LEN + 1 + j;
            n = e - stages;
            if (s[TOTAL-n] != PAT[SYNC_W-1-j]) bad = 1'b1;
        end
        return bad;
    endfunction

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!word_ready && n < 100) begin
            @(negedge prog_clk);
            n++;
        end
        chk(name, word_ready, 1'b1);
    endtask

    task automatic feed_word(input logic [7:0] w, input int gap);
        if (gap > 0) begin
            wait_ready("stall_ready_wait");
            for (int g = 0; g < gap; g++) begin
                @(negedge prog_clk);
                chk("stall_clk_en", ccff_clk_en, 1'b0);
            end
        end
        word_valid = 1'b1;
        word_in    = w;
        wait_ready("word_ready_wait");
        @(negedge prog_clk);
        word_valid = 1'b0;
    endtask

    task automatic finish_check(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                                input int stages, input int base_e, input int base_h);
        logic [23:0] exp_s;
        logic        exp_e;
        int          n;
        exp_s = model_stream(a, b, c);
        exp_e = model_err(exp_s, stages);
        n = 0;
        while (!(done || error) && n < 200) begin
            @(negedge prog_clk);
            n++;
        end
        chk("end_reached", done || error, 1'b1);
        chk("end_latency", cyc - last_edge_cyc, 0);
        chk("end_clk_en", ccff_clk_en, 1'b0);
        chk("end_busy", busy, 1'b0);
        chk("done", done, !exp_e);
        chk("error", error, exp_e);
        chk("edge_count", edges - base_e, TOTAL);
        chk("head_stream", stream_cap, exp_s);
        chk("chain_contents", chain, exp_s[CHAIN_LEN-1:0]);
        chk("words_accepted", hs_cnt - base_h, 3);
        chk("accepted_data", acc_w, {a, b, c});
        repeat (3) @(negedge prog_clk);
        chk("edge_count_hold", edges - base_e, TOTAL);
        chk("done_hold", done, !exp_e);
    endtask

    task automatic run_load(input vec_t v);
        int base_e;
        int base_h;
        base_e       = edges;
        base_h       = hs_cnt;
        chain_stages = v.stages;
        start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1'b1);
        chk("done_after_start", done | error, 1'b0);
        if (v.spam) begin
            start = 1'b1;
            @(negedge prog_clk);
            start = 1'b0;
        end
        feed_word(v.w0, 0);
        if (v.spam) begin
            start = 1'b1;
            @(negedge prog_clk);
            start = 1'b0;
        end
        feed_word(v.w1, v.gap);
        feed_word(v.w2, v.gap);
        finish_check(v.w0, v.w1, v.w2, v.stages, base_e, base_h);
    endtask

    initial begin
        int   base_e;
        int   base_h;
        int   n;
        vec_t r;

        tbl[0] = '{8'hC3, 8'h5A, 8'hF0, 0, 20, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{8'hC3, 8'h5A, 8'hF0, 5, 20, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{8'hC3, 8'h5A, 8'hF0, 0, 19, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{8'hC3, 8'h5A, 8'hF0, 0, 20, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{8'h00, 8'hFF, 8'h0F, 2, 20, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{8'hFF, 8'hFF, 8'hFF, 0, 19, 1'b1, 1'b0, 1'b1};

        start      = 1'b0;
        word_valid = 1'b0;
        word_in    = '0;
        prog_rst_n = 1'b0;
        repeat (3) @(negedge prog_clk);
        chk("rst_word_ready", word_ready, 1'b0);
        chk("rst_head", ccff_head, 1'b0);
        chk("rst_clk_en", ccff_clk_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        prog_rst_n = 1'b1;
        @(negedge prog_clk);

        // Backpressure: a word waiting in IDLE must not be taken before DATA.
        base_e     = edges;
        base_h     = hs_cnt;
        word_valid = 1'b1;
        word_in    = 8'h3C;
        repeat (3) @(negedge prog_clk);
        chk("bp_ready_idle", word_ready, 1'b0);
        chk("bp_no_accept_idle", hs_cnt - base_h, 0);
        start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
        chk("bp_no_accept_start", hs_cnt - base_h, 0);
        wait_ready("bp_ready_wait");
        chk("bp_first_data_cycle", edges - base_e, SYNC_W);
        chk("bp_no_accept_sync", hs_cnt - base_h, 0);
        @(negedge prog_clk);
        word_valid = 1'b0;
        chk("bp_accept_count", hs_cnt - base_h, 1);
        chk("bp_accept_word", acc_w[7:0], 8'h3C);
        feed_word(8'h96, 0);
        feed_word(8'h71, 0);
        finish_check(8'h3C, 8'h96, 8'h71, CHAIN_LEN, base_e, base_h);

        // Directed vectors (each starts from DONE or ERROR of the previous load).
        for (int i = 0; i < 6; i++) begin
            run_load(tbl[i]);
            chk("tbl_done", done, tbl[i].exp_done);
            chk("tbl_error", error, tbl[i].exp_err);
        end

        // Reset in the middle of DATA.
        chain_stages = CHAIN_LEN;
        base_e = edges;
        start  = 1'b1;
        @(negedge prog_clk);
        start      = 1'b0;
        word_valid = 1'b1;
        word_in    = 8'hC3;
        n = 0;
        while ((edges - base_e) < 10 && n < 100) begin
            @(negedge prog_clk);
            n++;
        end
        chk("mid_rst_edge10", edges - base_e, 10);
        prog_rst_n = 1'b0;
        #1;
        chk("mid_rst_word_ready", word_ready, 1'b0);
        chk("mid_rst_head", ccff_head, 1'b0);
        chk("mid_rst_clk_en", ccff_clk_en, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_error", error, 1'b0);
        @(negedge prog_clk);
        word_valid = 1'b0;
        @(negedge prog_clk);
        prog_rst_n = 1'b1;
        @(negedge prog_clk);
        run_load(tbl[0]);

        // Randomised loads against the model.
        for (int i = 0; i < 16; i++) begin
            r.w0       = 8'($urandom);
            r.w1       = 8'($urandom);
            r.w2       = 8'($urandom);
            r.gap      = int'($urandom_range(0, 3));
            r.stages   = ($urandom_range(0, 3) == 0) ? CHAIN_LEN - 1 : CHAIN_LEN;
            r.spam     = 1'($urandom_range(0, 1));
            r.exp_done = 1'b0;
            r.exp_err  = 1'b0;
            run_load(r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
